rmst_rd_arbiter: RTL and testbench

Two-requester arbiter that shares the single Avalon read master (raddr / iolen / trans_start / trans_done) between the input-feature-map load controller (requester 0) and the weight load controller (requester 1). It latches one-cycle start pulses with their address and length, grants the master to one requester at a time, forwards its burst parameters, and routes the master's done pulse back to the granted requester only. It sits between the per-tile load controllers and the Avalon read master in the conv accelerator top level.

---
 rtl/rmst_rd_arbiter.sv | 149 ++++++++++++++
 tb/tb_rmst_rd_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rmst_rd_arbiter.sv
// rmst_rd_arbiter: shares one Avalon read master between the IFM load
// controller (requester 0) and the weight load controller (requester 1).
// Start pulses are latched with their address/length, one requester is
// granted at a time, and the master's done pulse is routed back to the
// requester that owns the burst.
// Build option: define RMST_ARB_FIXED_PRIO_EN to give requester 0 fixed
// priority when both are pending; otherwise arbitration is round robin.
//
//   state | meaning
//   IDLE  | no burst outstanding, grant a pending requester if any
//   WAIT  | burst issued to read master, waiting for m_done
module rmst_rd_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_start,
  input  logic [DW-1:0] req0_raddr,
  input  logic [AW-1:0] req0_iolen,
  output logic          req0_done,
  input  logic          req1_start,
  input  logic [DW-1:0] req1_raddr,
  input  logic [AW-1:0] req1_iolen,
  output logic          req1_done,
  output logic          m_start,
  output logic [DW-1:0] m_raddr,
  output logic [AW-1:0] m_iolen,
  input  logic          m_done,
  output logic          busy,
  output logic          grant_id,
  output logic          req_ovf,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_nxt;
  logic          pend0, pend1;
  logic [DW-1:0] cap_raddr0, cap_raddr1;
  logic [AW-1:0] cap_iolen0, cap_iolen1;
  logic          grant_vld;
  logic          grant_sel;
  logic          done_vld;
  logic          clr0, clr1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and arbitration decision.
  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_sel = grant_id;
    done_vld  = 1'b0;
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          grant_vld = 1'b1;
          state_nxt = WAIT;
          if (pend0 && pend1) begin
`ifdef RMST_ARB_FIXED_PRIO_EN
            grant_sel = 1'b0;
`else
            grant_sel = ~grant_id;
`endif
          end else begin
            grant_sel = pend1;
          end
        end
      end
      WAIT: begin
        if (m_done) begin
          done_vld  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr0 = grant_vld & ~grant_sel;
  assign clr1 = grant_vld &  grant_sel;
  assign busy = (state == WAIT);

  // Pending flags and captures; a new start wins over a same-cycle grant clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      cap_raddr0 <= '0;
      cap_raddr1 <= '0;
      cap_iolen0 <= '0;
      cap_iolen1 <= '0;
      req_ovf    <= 1'b0;
    end else begin
      pend0 <= req0_start | (pend0 & ~clr0);
      pend1 <= req1_start | (pend1 & ~clr1);
      if (req0_start) begin
        cap_raddr0 <= req0_raddr;
        cap_iolen0 <= req0_iolen;
      end
      if (req1_start) begin
        cap_raddr1 <= req1_raddr;
        cap_iolen1 <= req1_iolen;
      end
      if ((req0_start & pend0 & ~clr0) | (req1_start & pend1 & ~clr1))
        req_ovf <= 1'b1;
    end
  end

  // Master-side outputs: burst parameters hold until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_start  <= 1'b0;
      m_raddr  <= '0;
      m_iolen  <= '0;
      grant_id <= 1'b0;
    end else begin
      m_start <= grant_vld;
      if (grant_vld) begin
        grant_id <= grant_sel;
        m_raddr  <= grant_sel ? cap_raddr1 : cap_raddr0;
        m_iolen  <= grant_sel ? cap_iolen1 : cap_iolen0;
      end
    end
  end

  // Completion routing and per-requester burst counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else begin
      req0_done <= done_vld & ~grant_id;
      req1_done <= done_vld &  grant_id;
      if (done_vld & ~grant_id) cnt0 <= cnt0 + CW'(1);
      if (done_vld &  grant_id) cnt1 <= cnt1 + CW'(1);
    end
  end

endmodule

// File: tb/tb_rmst_rd_arbiter.sv
// Bench for rmst_rd_arbiter: directed stimulus with a scoreboard of expected
// grants and completions checked by an independent monitor.
module tb_rmst_rd_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_start = 1'b0, req1_start = 1'b0, m_done = 1'b0;
  logic [DW-1:0] req0_raddr = '0, req1_raddr = '0;
  logic [AW-1:0] req0_iolen = '0, req1_iolen = '0;
  logic          req0_done, req1_done, m_start, busy, grant_id, req_ovf;
  logic [DW-1:0] m_raddr;
  logic [AW-1:0] m_iolen;
  logic [CW-1:0] cnt0, cnt1;

  rmst_rd_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_start(req0_start), .req0_raddr(req0_raddr), .req0_iolen(req0_iolen), .req0_done(req0_done),
    .req1_start(req1_start), .req1_raddr(req1_raddr), .req1_iolen(req1_iolen), .req1_done(req1_done),
    .m_start(m_start), .m_raddr(m_raddr), .m_iolen(m_iolen), .m_done(m_done),
    .busy(busy), .grant_id(grant_id), .req_ovf(req_ovf), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  typedef struct { logic id; logic [DW-1:0] addr; logic [AW-1:0] len; } grant_t;
  typedef struct { logic id; logic [CW-1:0] cnt; } done_t;

  grant_t gq[$];
  done_t  dq[$];
  int     n_chk = 0;
  int     n_pass = 0;
  logic   prev_mstart = 1'b0;
  grant_t g;
  done_t  d;
  logic [CW-1:0] exp_cnt0 = '0, exp_cnt1 = '0;
  logic [DW-1:0] last_addr0, last_addr1;
  logic [AW-1:0] last_len0, last_len1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare every grant and every completion against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_start) begin
        chk("m_start_width", 64'(prev_mstart), 64'(0));
        if (gq.size() == 0) chk("unexpected_m_start", 64'(1), 64'(0));
        else begin
          g = gq.pop_front();
          chk("grant_id", 64'(grant_id), 64'(g.id));
          chk("m_raddr", 64'(m_raddr), 64'(g.addr));
          chk("m_iolen", 64'(m_iolen), 64'(g.len));
          chk("busy_on_start", 64'(busy), 64'(1));
        end
      end
      if (req0_done || req1_done) begin
        if (dq.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
        else begin
          d = dq.pop_front();
          chk("done_vec", 64'({req1_done, req0_done}), d.id ? 64'(2) : 64'(1));
          chk("done_cnt", d.id ? 64'(cnt1) : 64'(cnt0), 64'(d.cnt));
          chk("busy_after_done", 64'(busy), 64'(0));
        end
      end
      prev_mstart = m_start;
    end else begin
      prev_mstart = 1'b0;
    end
  end

  // One-cycle drive of starts and/or m_done.
  task automatic drive(input logic s0, input logic [DW-1:0] a0, input logic [AW-1:0] l0,
                       input logic s1, input logic [DW-1:0] a1, input logic [AW-1:0] l1,
                       input logic dn);
    @(posedge clk); #1;
    req0_start = s0; req0_raddr = a0; req0_iolen = l0;
    req1_start = s1; req1_raddr = a1; req1_iolen = l1;
    m_done = dn;
    @(posedge clk); #1;
    req0_start = 1'b0; req1_start = 1'b0; m_done = 1'b0;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!m_start && cyc < 20);
    if (!m_start) chk("grant_timeout", 64'(0), 64'(1));
  endtask

  task automatic push_grant(input logic id, input logic [DW-1:0] a, input logic [AW-1:0] l);
    grant_t t;
    t.id = id; t.addr = a; t.len = l;
    gq.push_back(t);
  endtask

  task automatic push_done(input logic id);
    done_t t;
    if (id) begin exp_cnt1 = exp_cnt1 + 1'b1; t.cnt = exp_cnt1; end
    else    begin exp_cnt0 = exp_cnt0 + 1'b1; t.cnt = exp_cnt0; end
    t.id = id;
    dq.push_back(t);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {m_start, busy, grant_id, req_ovf, req0_done, req1_done,
               m_raddr, m_iolen, cnt0, cnt1}, 64'(0));
  endtask

  initial begin
    int  lat;
    logic id;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_outputs");
    rst = 1'b0;

    // Single request from requester 0.
    push_grant(1'b0, 32'h40000, 12'd16);
    drive(1'b1, 32'h40000, 12'd16, 1'b0, '0, '0, 1'b0);
    wait_grant(lat);
    chk("req_to_start_latency", 64'(lat), 64'(2));
    push_done(1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    repeat (2) @(negedge clk);

    // Simultaneous requests with grant_id = 0.
`ifdef RMST_ARB_FIXED_PRIO_EN
    push_grant(1'b0, 32'h1000, 12'd7);
    push_grant(1'b1, 32'h2000, 12'd9);
    drive(1'b1, 32'h1000, 12'd7, 1'b1, 32'h2000, 12'd9, 1'b0);
    wait_grant(lat); push_done(1'b0); drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    wait_grant(lat); push_done(1'b1); drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
`else
    push_grant(1'b1, 32'h2000, 12'd9);
    push_grant(1'b0, 32'h1000, 12'd7);
    drive(1'b1, 32'h1000, 12'd7, 1'b1, 32'h2000, 12'd9, 1'b0);
    wait_grant(lat); push_done(1'b1); drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    wait_grant(lat); push_done(1'b0); drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
`endif
    repeat (2) @(negedge clk);

    // Alternation: each granted requester re-requests alongside its m_done.
    last_addr0 = 32'h5000; last_len0 = 12'd3;
    last_addr1 = 32'h6000; last_len1 = 12'd5;
    drive(1'b1, last_addr0, last_len0, 1'b1, last_addr1, last_len1, 1'b0);
    for (int k = 0; k < 8; k++) begin
`ifdef RMST_ARB_FIXED_PRIO_EN
      id = 1'b0;
`else
      id = (k % 2 == 0);
`endif
      if (id) push_grant(1'b1, last_addr1, last_len1);
      else    push_grant(1'b0, last_addr0, last_len0);
      wait_grant(lat);
      if (k > 0) chk("done_to_start_latency", 64'(lat), 64'(2));
      push_done(id);
      if (k < 7) begin
        if (id) begin
          last_addr1 = 32'h9000 + 32'(k * 16); last_len1 = 12'(k + 20);
          drive(1'b0, '0, '0, 1'b1, last_addr1, last_len1, 1'b1);
        end else begin
          last_addr0 = 32'h8000 + 32'(k * 16); last_len0 = 12'(k + 10);
          drive(1'b1, last_addr0, last_len0, 1'b0, '0, '0, 1'b1);
        end
      end else begin
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      end
    end
    push_grant(1'b1, last_addr1, last_len1);
    wait_grant(lat);
    push_done(1'b1);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    repeat (2) @(negedge clk);
    chk("ovf_clear_before", 64'(req_ovf), 64'(0));

    // Overflow: requester 1 starts twice while requester 0 holds the master.
    push_grant(1'b0, 32'h300, 12'd8);
    drive(1'b1, 32'h300, 12'd8, 1'b0, '0, '0, 1'b0);
    wait_grant(lat);
    drive(1'b0, '0, '0, 1'b1, 32'h100, 12'd1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 32'h200, 12'd2, 1'b0);
    chk("ovf_set", 64'(req_ovf), 64'(1));
    push_done(1'b0);
    push_grant(1'b1, 32'h200, 12'd2);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    wait_grant(lat);
    push_done(1'b1);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    repeat (2) @(negedge clk);
    chk("ovf_sticky", 64'(req_ovf), 64'(1));

    // Spurious m_done in IDLE.
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    repeat (3) @(negedge clk);
    chk("spurious_cnt0", 64'(cnt0), 64'(exp_cnt0));
    chk("spurious_cnt1", 64'(cnt1), 64'(exp_cnt1));
    chk("spurious_busy", 64'(busy), 64'(0));

    // Reset while a burst is outstanding; a late m_done must be ignored.
    push_grant(1'b0, 32'h7000, 12'd4);
    drive(1'b1, 32'h7000, 12'd4, 1'b0, '0, '0, 1'b0);
    wait_grant(lat);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_all_zero("reset_mid_burst");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt0 = '0; exp_cnt1 = '0;
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    repeat (3) @(negedge clk);
    chk("late_done_cnt", 64'({cnt1, cnt0}), 64'(0));
    chk("late_done_busy", 64'(busy), 64'(0));

    // Counter wrap: 16 bursts from requester 0 with a 4-bit counter.
    for (int k = 0; k < 16; k++) begin
      push_grant(1'b0, 32'hA000 + 32'(k * 64), 12'(k + 1));
      drive(1'b1, 32'hA000 + 32'(k * 64), 12'(k + 1), 1'b0, '0, '0, 1'b0);
      wait_grant(lat);
      push_done(1'b0);
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("cnt0_wrapped", 64'(cnt0), 64'(0));
    chk("grant_queue_drained", 64'(gq.size()), 64'(0));
    chk("done_queue_drained", 64'(dq.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
